set_assoc_tag_lookup: RTL

Parametrised N-way set-associative cache lookup engine with integrated tag, valid and data arrays, true-LRU replacement and a sequential flush. It generalises the fixed 4-way, 32-bit path (22-bit tag compare, one-hot hit to way select, 4:1 data mux) into one registered block with configurable width, depth and associativity. It sits between the cache controller FSM and the backing-memory fill path. It answers read lookups with hit/data or miss/victim, and accepts fills that allocate lines.

---
 rtl/set_assoc_tag_lookup_if.sv | 49 ++++
 rtl/set_assoc_tag_lookup.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_tag_lookup_if.sv
// -----------------------------------------------------------------------------
// set_assoc_tag_lookup_if
// Bundles the request, flush and response signals of set_assoc_tag_lookup.
//
// Handshake rules:
//   - A request transfers on a rising clk edge where req_valid && req_ready.
//   - The master holds req_write/req_index/req_tag/req_data stable while
//     req_valid is high and req_ready is low.
//   - flush_start is a one-cycle pulse. It only has an effect while the
//     engine is idle, and it wins over a simultaneous request.
//   - resp_valid is a one-cycle strobe with no backpressure. resp_hit,
//     resp_way and resp_data hold their values until the next response.
//
// Modports:
//   master : cache controller side (drives requests and flush)
//   slave  : lookup engine side (drives ready, busy and response)
// -----------------------------------------------------------------------------
interface set_assoc_tag_lookup_if #(
   parameter int WAYS   = 4,
   parameter int SETS   = 64,
   parameter int TAG_W  = 22,
   parameter int DATA_W = 32
);
   localparam int WAY_W = $clog2(WAYS);
   localparam int IDX_W = $clog2(SETS);

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [IDX_W-1:0]  req_index;
   logic [TAG_W-1:0]  req_tag;
   logic [DATA_W-1:0] req_data;
   logic              flush_start;
   logic              flush_busy;
   logic              resp_valid;
   logic              resp_hit;
   logic [WAY_W-1:0]  resp_way;
   logic [DATA_W-1:0] resp_data;

   modport master (
      output req_valid, req_write, req_index, req_tag, req_data, flush_start,
      input  req_ready, flush_busy, resp_valid, resp_hit, resp_way, resp_data
   );

   modport slave (
      input  req_valid, req_write, req_index, req_tag, req_data, flush_start,
      output req_ready, flush_busy, resp_valid, resp_hit, resp_way, resp_data
   );
endinterface

// File: rtl/set_assoc_tag_lookup.sv
// -----------------------------------------------------------------------------
// set_assoc_tag_lookup
// N-way set-associative lookup engine with tag, valid and data arrays,
// true-LRU replacement (per-way ages) and a one-set-per-cycle flush.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bus        : set_assoc_tag_lookup_if.slave (request / flush / response)
//   fsm_state  : current FSM state (IDLE=0, LOOK=1, RESP=2, FLUSH=3)
//
// Flow: IDLE accepts a request -> LOOK compares it and updates the arrays ->
// RESP strobes resp_valid -> IDLE. FLUSH walks all sets, clearing valid bits
// and restoring ages to age[i] = i.
// -----------------------------------------------------------------------------
module set_assoc_tag_lookup #(
   parameter int WAYS   = 4,
   parameter int SETS   = 64,
   parameter int TAG_W  = 22,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   set_assoc_tag_lookup_if.slave      bus,
   output logic [1:0]                 fsm_state
);
   localparam int WAY_W = $clog2(WAYS);
   localparam int IDX_W = $clog2(SETS);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOOK  = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;
   localparam logic [1:0] FLUSH = 2'd3;

   logic [1:0] state;

   // Arrays: valid and age are reset; tag and data are not.
   logic [WAYS-1:0]   valid_mem [SETS];
   logic [WAY_W-1:0]  age_mem   [SETS][WAYS];
   logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
   logic [DATA_W-1:0] data_mem  [SETS][WAYS];

   // Registered request
   logic              r_write;
   logic [IDX_W-1:0]  r_index;
   logic [TAG_W-1:0]  r_tag;
   logic [DATA_W-1:0] r_data;

   logic [IDX_W-1:0]  flush_cnt;

   // Registered response
   logic              resp_hit_q;
   logic [WAY_W-1:0]  resp_way_q;
   logic [DATA_W-1:0] resp_data_q;

   // Lookup datapath (evaluated against the registered request)
   logic              hit_any;
   logic [WAY_W-1:0]  hit_way;
   logic              inv_found;
   logic [WAY_W-1:0]  victim;
   logic [WAY_W-1:0]  target_way;
   logic [WAY_W-1:0]  target_age;
   logic              do_touch;
   logic [WAY_W-1:0]  age_nxt [WAYS];

   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_mem[r_index][w] && (tag_mem[r_index][w] == r_tag)) begin
            hit_any = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Lowest-index invalid way; scanning downward leaves the lowest one last.
   // With the set full, the oldest way (age WAYS-1) is the victim.
   always_comb begin
      inv_found = 1'b0;
      victim    = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_mem[r_index][w]) begin
            inv_found = 1'b1;
            victim    = WAY_W'(w);
         end
      end
      if (!inv_found) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_mem[r_index][w] == WAY_W'(WAYS - 1)) begin
               victim = WAY_W'(w);
            end
         end
      end
   end

   assign target_way = hit_any ? hit_way : victim;
   assign target_age = age_mem[r_index][target_way];
   // A lookup miss leaves LRU untouched; hits and every fill touch.
   assign do_touch   = hit_any || r_write;

   // Touch: ways younger than the touched way age by one, touched way -> 0.
   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         if (WAY_W'(w) == target_way) begin
            age_nxt[w] = '0;
         end else if (age_mem[r_index][w] < target_age) begin
            age_nxt[w] = age_mem[r_index][w] + 1'b1;
         end else begin
            age_nxt[w] = age_mem[r_index][w];
         end
      end
   end

   // Control, request capture, valid/age arrays and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         r_write     <= 1'b0;
         r_index     <= '0;
         r_tag       <= '0;
         r_data      <= '0;
         flush_cnt   <= '0;
         resp_hit_q  <= 1'b0;
         resp_way_q  <= '0;
         resp_data_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_mem[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               age_mem[s][w] <= WAY_W'(w);
            end
         end
      end else begin
         case (state)
            IDLE: begin
               if (bus.flush_start) begin
                  state     <= FLUSH;
                  flush_cnt <= '0;
               end else if (bus.req_valid) begin
                  state   <= LOOK;
                  r_write <= bus.req_write;
                  r_index <= bus.req_index;
                  r_tag   <= bus.req_tag;
                  r_data  <= bus.req_data;
               end
            end
            LOOK: begin
               resp_hit_q  <= hit_any;
               resp_way_q  <= target_way;
               resp_data_q <= (!r_write && hit_any) ? data_mem[r_index][hit_way] : '0;
               if (do_touch) begin
                  for (int w = 0; w < WAYS; w++) begin
                     age_mem[r_index][w] <= age_nxt[w];
                  end
               end
               if (r_write && !hit_any) begin
                  valid_mem[r_index][victim] <= 1'b1;
               end
               state <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            FLUSH: begin
               valid_mem[flush_cnt] <= '0;
               for (int w = 0; w < WAYS; w++) begin
                  age_mem[flush_cnt][w] <= WAY_W'(w);
               end
               flush_cnt <= flush_cnt + 1'b1;
               if (flush_cnt == IDX_W'(SETS - 1)) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag/data storage has no reset; a fill writes the hit way or the victim.
   always_ff @(posedge clk) begin
      if (rst_n && (state == LOOK) && r_write) begin
         tag_mem[r_index][target_way]  <= r_tag;
         data_mem[r_index][target_way] <= r_data;
      end
   end

   assign bus.req_ready  = (state == IDLE) && !bus.flush_start;
   assign bus.flush_busy = (state == FLUSH);
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_hit   = resp_hit_q;
   assign bus.resp_way   = resp_way_q;
   assign bus.resp_data  = resp_data_q;
   assign fsm_state      = state;

endmodule
